imem_fetch_responder: RTL and testbench

- Instruction-memory responder: the memory end of the fetch interface that the PC stage drives.
- Accepts fetch requests (word address from pc) through a valid/ready handshake.
- Returns the 32-bit instruction after a fixed, parameterised latency.
- Holds each response until decode accepts it; includes a bench/loader write port and a wrapping fetch counter.

---
 rtl/imem_fetch_responder_if.sv | 23 ++
 rtl/imem_fetch_responder.sv | 134 +++++++++++++
 tb/tb_imem_fetch_responder.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_fetch_responder_if.sv
// Fetch request/response bus between the PC stage (master) and instruction memory (slave).
interface imem_fetch_responder_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_instr;
    logic [ADDR_W-1:0] resp_addr;

    modport master (
        output req_valid, req_addr, resp_ready,
        input  req_ready, resp_valid, resp_instr, resp_addr
    );

    modport slave (
        input  req_valid, req_addr, resp_ready,
        output req_ready, resp_valid, resp_instr, resp_addr
    );
endinterface

// File: rtl/imem_fetch_responder.sv
// Instruction-memory fetch responder: fixed-latency read, response held until accepted.
// Optional abort input 'flush' is enabled by defining IMEM_FLUSH_EN.
module imem_fetch_responder #(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LATENCY = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    imem_fetch_responder_if.slave bus,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
`ifdef IMEM_FLUSH_EN
    input  logic                flush,
`endif
    output logic                busy,
    output logic [7:0]          fetch_count
);

    localparam int unsigned Depth = 1 << ADDR_W;
    localparam logic [3:0] LatInit = 4'(LATENCY - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    logic [DATA_W-1:0] mem [Depth];

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic              rvalid_q, rvalid_d;
    logic [7:0]        count_q, count_d;
    logic              flush_w;

`ifdef IMEM_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    // Memory is not reset; a read on the same edge as a write sees the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        instr_d  = instr_q;
        raddr_d  = raddr_q;
        rvalid_d = rvalid_q;
        count_d  = count_q;
        case (state_q)
            StIdle: begin
                if (!flush_w && bus.req_valid) begin
                    addr_d = bus.req_addr;
                    if (LATENCY == 1) begin
                        state_d  = StResp;
                        cnt_d    = 4'd0;
                        instr_d  = mem[bus.req_addr];
                        raddr_d  = bus.req_addr;
                        rvalid_d = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = LatInit;
                    end
                end
            end
            StWait: begin
                if (flush_w) begin
                    state_d = StIdle;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d  = StResp;
                    instr_d  = mem[addr_q];
                    raddr_d  = addr_q;
                    rvalid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                // A flush wins over a simultaneous handshake and is not counted.
                if (flush_w) begin
                    state_d  = StIdle;
                    rvalid_d = 1'b0;
                end else if (bus.resp_ready) begin
                    state_d  = StIdle;
                    rvalid_d = 1'b0;
                    count_d  = count_q + 8'd1;
                end
            end
            default: begin
                state_d  = StIdle;
                rvalid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            addr_q   <= '0;
            instr_q  <= '0;
            raddr_q  <= '0;
            rvalid_q <= 1'b0;
            count_q  <= 8'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            instr_q  <= instr_d;
            raddr_q  <= raddr_d;
            rvalid_q <= rvalid_d;
            count_q  <= count_d;
        end
    end

    assign bus.req_ready  = (state_q == StIdle);
    assign bus.resp_valid = rvalid_q;
    assign bus.resp_instr = instr_q;
    assign bus.resp_addr  = raddr_q;
    assign busy           = (state_q == StWait) || (state_q == StResp);
    assign fetch_count    = count_q;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed bench for imem_fetch_responder with a response scoreboard; LATENCY=2 and LATENCY=1 DUTs.
module tb_imem_fetch_responder;

    localparam int LAT = 2;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        busy0, busy1;
    logic [7:0]  fc0, fc1;
`ifdef IMEM_FLUSH_EN
    logic        flush = 1'b0;
`endif

    imem_fetch_responder_if #(.ADDR_W(5), .DATA_W(32)) if0 ();
    imem_fetch_responder_if #(.ADDR_W(5), .DATA_W(32)) if1 ();

    imem_fetch_responder #(.ADDR_W(5), .DATA_W(32), .LATENCY(LAT)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (if0),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
`ifdef IMEM_FLUSH_EN
        .flush      (flush),
`endif
        .busy       (busy0),
        .fetch_count(fc0)
    );

    imem_fetch_responder #(.ADDR_W(5), .DATA_W(32), .LATENCY(1)) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (if1),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
`ifdef IMEM_FLUSH_EN
        .flush      (flush),
`endif
        .busy       (busy1),
        .fetch_count(fc1)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          checks = 0;
    int          failures = 0;
    int          acc_cyc = 0;
    logic [7:0]  exp_cnt = 8'd0;
    logic [31:0] tb_mem [32];
    exp_t        exp_q [$];
    exp_t        last_e;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic mem_write(input logic [4:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
        tb_mem[a] = d;
    endtask

    // Drive one request across an edge and record the expected response.
    task automatic issue(input logic [4:0] a, input logic [31:0] e);
        exp_t item;
        if0.req_valid = 1'b1;
        if0.req_addr  = a;
        chk("req_ready_idle", {63'd0, if0.req_ready}, 64'd1);
        item.addr  = a;
        item.instr = e;
        exp_q.push_back(item);
        @(negedge clk);
        if0.req_valid = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic wait_resp();
        int n = 0;
        while (!if0.resp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("resp_valid_timeout", {63'd0, if0.resp_valid}, 64'd1);
        chk("latency", 64'(cyc - acc_cyc), 64'(LAT));
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 64'd0, 64'(exp_q.size() + 1));
        end else begin
            last_e = exp_q.pop_front();
            chk("resp_instr", {32'd0, if0.resp_instr}, {32'd0, last_e.instr});
            chk("resp_addr", {59'd0, if0.resp_addr}, {59'd0, last_e.addr});
        end
    endtask

    // Hold the response for 'hold' cycles (optionally overwriting its word), then accept it.
    task automatic take(input int hold, input bit wr_mid);
        for (int i = 0; i < hold; i++) begin
            chk("hold_valid", {63'd0, if0.resp_valid}, 64'd1);
            chk("hold_req_ready", {63'd0, if0.req_ready}, 64'd0);
            chk("hold_busy", {63'd0, busy0}, 64'd1);
            chk("hold_instr", {32'd0, if0.resp_instr}, {32'd0, last_e.instr});
            chk("hold_addr", {59'd0, if0.resp_addr}, {59'd0, last_e.addr});
            if (wr_mid && i == 0) begin
                wr_en   = 1'b1;
                wr_addr = last_e.addr;
                wr_data = ~last_e.instr;
            end
            @(negedge clk);
            if (wr_en) begin
                wr_en = 1'b0;
                tb_mem[wr_addr] = wr_data;
            end
        end
        if0.resp_ready = 1'b1;
        @(negedge clk);
        if0.resp_ready = 1'b0;
        exp_cnt = exp_cnt + 8'd1;
        chk("post_hs_valid", {63'd0, if0.resp_valid}, 64'd0);
        chk("post_hs_req_ready", {63'd0, if0.req_ready}, 64'd1);
        chk("post_hs_busy", {63'd0, busy0}, 64'd0);
        chk("fetch_count", {56'd0, fc0}, {56'd0, exp_cnt});
    endtask

    initial begin
        #2ms;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        if0.req_valid = 1'b0;
        if0.req_addr = '0;
        if0.resp_ready = 1'b0;
        if1.req_valid = 1'b0;
        if1.req_addr = '0;
        if1.resp_ready = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_resp_valid", {63'd0, if0.resp_valid}, 64'd0);
        chk("rst_resp_instr", {32'd0, if0.resp_instr}, 64'd0);
        chk("rst_resp_addr", {59'd0, if0.resp_addr}, 64'd0);
        chk("rst_req_ready", {63'd0, if0.req_ready}, 64'd1);
        chk("rst_busy", {63'd0, busy0}, 64'd0);
        chk("rst_fetch_count", {56'd0, fc0}, 64'd0);

        for (int a = 0; a < 32; a++) begin
            mem_write(5'(a), $urandom);
        end
        mem_write(5'd5, 32'h8C010004);
        mem_write(5'd12, 32'h11111111);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic fetch with consumer already ready.
        if0.resp_ready = 1'b1;
        issue(5'd5, tb_mem[5]);
        wait_resp();
        take(0, 1'b0);

        // Back-pressure with a write to the held word during RESP.
        issue(5'd9, tb_mem[9]);
        wait_resp();
        take(4, 1'b1);
        issue(5'd9, tb_mem[9]);
        wait_resp();
        take(0, 1'b0);

        // Write one edge before latency expiry is visible.
        issue(5'd12, 32'h00000020);
        mem_write(5'd12, 32'h00000020);
        wait_resp();
        take(0, 1'b0);

        // Write on the expiry edge returns the old word.
        issue(5'd12, tb_mem[12]);
        @(negedge clk);
        mem_write(5'd12, 32'h33333333);
        wait_resp();
        take(0, 1'b0);
        issue(5'd12, tb_mem[12]);
        wait_resp();
        take(0, 1'b0);

        // Async reset in WAIT, then in RESP.
        issue(5'd5, tb_mem[5]);
        #2 rst_n = 1'b0;
        #1;
        chk("rstw_resp_valid", {63'd0, if0.resp_valid}, 64'd0);
        chk("rstw_req_ready", {63'd0, if0.req_ready}, 64'd1);
        chk("rstw_busy", {63'd0, busy0}, 64'd0);
        chk("rstw_fetch_count", {56'd0, fc0}, 64'd0);
        exp_q.delete();
        exp_cnt = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;
        issue(5'd5, tb_mem[5]);
        wait_resp();
        #2 rst_n = 1'b0;
        #1;
        chk("rstr_resp_valid", {63'd0, if0.resp_valid}, 64'd0);
        chk("rstr_resp_instr", {32'd0, if0.resp_instr}, 64'd0);
        chk("rstr_resp_addr", {59'd0, if0.resp_addr}, 64'd0);
        chk("rstr_req_ready", {63'd0, if0.req_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        issue(5'd5, 32'h8C010004);
        wait_resp();
        take(0, 1'b0);

        // 255 more completed fetches wrap the counter to zero.
        for (int i = 0; i < 255; i++) begin
            issue(5'(i % 32), tb_mem[i % 32]);
            wait_resp();
            take(0, 1'b0);
        end
        chk("fetch_count_wrap", {56'd0, fc0}, 64'd0);

`ifdef IMEM_FLUSH_EN
        issue(5'd3, tb_mem[3]);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        exp_q.delete();
        chk("flushw_resp_valid", {63'd0, if0.resp_valid}, 64'd0);
        chk("flushw_req_ready", {63'd0, if0.req_ready}, 64'd1);
        chk("flushw_count", {56'd0, fc0}, {56'd0, exp_cnt});
        repeat (3) @(negedge clk);
        chk("flushw_no_resp", {63'd0, if0.resp_valid}, 64'd0);

        if0.req_valid = 1'b1;
        if0.req_addr = 5'd7;
        flush = 1'b1;
        @(negedge clk);
        if0.req_valid = 1'b0;
        flush = 1'b0;
        chk("flushi_busy", {63'd0, busy0}, 64'd0);
        chk("flushi_req_ready", {63'd0, if0.req_ready}, 64'd1);

        issue(5'd4, tb_mem[4]);
        wait_resp();
        take(0, 1'b0);

        issue(5'd6, tb_mem[6]);
        wait_resp();
        flush = 1'b1;
        if0.resp_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        if0.resp_ready = 1'b0;
        chk("flushr_resp_valid", {63'd0, if0.resp_valid}, 64'd0);
        chk("flushr_count", {56'd0, fc0}, {56'd0, exp_cnt});
`endif

        // LATENCY=1 instance responds one edge after acceptance.
        if1.req_valid = 1'b1;
        if1.req_addr = 5'd5;
        chk("l1_req_ready", {63'd0, if1.req_ready}, 64'd1);
        @(negedge clk);
        if1.req_valid = 1'b0;
        chk("l1_resp_valid", {63'd0, if1.resp_valid}, 64'd1);
        chk("l1_resp_instr", {32'd0, if1.resp_instr}, 64'h8C010004);
        chk("l1_resp_addr", {59'd0, if1.resp_addr}, 64'd5);
        chk("l1_busy", {63'd0, busy1}, 64'd1);
        if1.resp_ready = 1'b1;
        @(negedge clk);
        if1.resp_ready = 1'b0;
        chk("l1_post_valid", {63'd0, if1.resp_valid}, 64'd0);
        chk("l1_fetch_count", {56'd0, fc1}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
